// File: rtl/max_delay_frame_rx.sv
// Framed single-wire receiver with a one-entry valid/ready output buffer.
// It returns a one-cycle ack (net2_out) or nak for each completed frame.
//
// Ports:
//   clk1        sole clock, all state updates on posedge
//   rst_n       asynchronous active-low reset
//   pin1        serial line, idle high, already synchronous to clk1
//   data_out    buffered frame payload
//   data_valid  data_out holds an unconsumed frame
//   data_ready  consumer accepts data_out when data_valid & data_ready
//   net2_out    ack pulse: a good frame entered the buffer
//   nak         pulse on parity error, framing error or overrun
//   parity_err  qualifies nak: even-parity mismatch
//   frame_err   qualifies nak: stop bit sampled low
//   overrun     qualifies nak: good frame dropped because the buffer was held
module max_delay_frame_rx #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PARITY_EN = 1
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              pin1,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              net2_out,
    output logic              nak,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_d;
    logic [DATA_W-1:0] shift_reg, shift_reg_d;
    logic              par_bit, par_bit_d;
    logic [DATA_W-1:0] data_out_d;
    logic              data_valid_d;
    logic              net2_out_d;
    logic              nak_d;
    logic              parity_err_d;
    logic              frame_err_d;
    logic              overrun_d;
    logic              handshake_c;
    logic              parity_ok_c;

    // State and registered outputs.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            net2_out   <= 1'b0;
            nak        <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_d;
            bit_cnt    <= bit_cnt_d;
            shift_reg  <= shift_reg_d;
            par_bit    <= par_bit_d;
            data_out   <= data_out_d;
            data_valid <= data_valid_d;
            net2_out   <= net2_out_d;
            nak        <= nak_d;
            parity_err <= parity_err_d;
            frame_err  <= frame_err_d;
            overrun    <= overrun_d;
        end
    end

    // Next-state, deserialiser, buffer and response pulses.
    always_comb begin
        state_d      = state;
        bit_cnt_d    = bit_cnt;
        shift_reg_d  = shift_reg;
        par_bit_d    = par_bit;
        data_out_d   = data_out;
        net2_out_d   = 1'b0;
        nak_d        = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;

        // A buffer freed this cycle can accept a frame completing this cycle.
        handshake_c  = data_valid & data_ready;
        data_valid_d = data_valid & ~handshake_c;

        // Without a parity bit every frame with a good stop bit is good.
        parity_ok_c = (PARITY_EN == 0) || (((^shift_reg) ^ par_bit) == 1'b0);

        case (state)
            S_IDLE: begin
                if (!pin1) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                shift_reg_d[bit_cnt] = pin1;
                if (bit_cnt == LAST_BIT) begin
                    state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end else begin
                    bit_cnt_d = bit_cnt + CNT_W'(1);
                end
            end
            S_PARITY: begin
                par_bit_d = pin1;
                state_d   = S_STOP;
            end
            S_STOP: begin
                if (pin1) begin
                    state_d = S_IDLE;
                    if (!parity_ok_c) begin
                        parity_err_d = 1'b1;
                        nak_d        = 1'b1;
                    end else if (data_valid && !data_ready) begin
                        overrun_d = 1'b1;
                        nak_d     = 1'b1;
                    end else begin
                        data_out_d   = shift_reg;
                        data_valid_d = 1'b1;
                        net2_out_d   = 1'b1;
                    end
                end else begin
                    // Line stuck low: report once, then wait for idle.
                    state_d     = S_WAIT_IDLE;
                    frame_err_d = 1'b1;
                    nak_d       = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (pin1) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
